// File: rtl/redmule_w_loader.sv
// Producer-side sequencer for the RedMulE W buffer: streams W rows (or dequant scale
// vectors) into the buffer one tile at a time, pads short tiles and tracks group indices.
module redmule_w_loader #(
    parameter int unsigned DW        = 288,
    parameter int unsigned FpFormat  = 2,
    parameter int unsigned Height    = 4,
    parameter int unsigned GID_WIDTH = 16,
    parameter int unsigned KW        = 16,
    localparam int unsigned BITW = (FpFormat == 0) ? 32 :
                                   (FpFormat == 1) ? 64 :
                                   (FpFormat == 2) ? 16 :
                                   (FpFormat == 4) ? 16 : 8,
    localparam int unsigned D    = DW / BITW,
    localparam int unsigned NCW  = $clog2(D) + 1,
    localparam int unsigned HW   = $clog2(Height) + 1,
    localparam int unsigned GIDW = $clog2(GID_WIDTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            start_i,
    input  logic [KW-1:0]   k_rows_i,
    input  logic [NCW-1:0]  n_cols_i,
    input  logic            dequant_i,
    input  logic [KW-1:0]   group_size_i,
    input  logic            w_valid_i,
    output logic            w_ready_o,
    input  logic [DW-1:0]   w_data_i,
    input  logic            refill_i,
    output logic            load_o,
    output logic [DW-1:0]   w_data_o,
    output logic [NCW-1:0]  width_o,
    output logic [HW-1:0]   height_o,
    output logic            dequant_o,
    output logic [GIDW-1:0] next_gidx_o,
    output logic            busy_o,
    output logic            tile_done_o,
    output logic            done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_WAIT_REFILL,
        S_DONE
    } state_t;

    localparam logic [HW-1:0]  H_FULL   = HW'(Height);
    localparam logic [HW-1:0]  ROW_LAST = HW'(Height - 1);
    localparam logic [NCW-1:0] D_MAX    = NCW'(D);

    state_t          r_state;
    logic [HW-1:0]   r_row;
    logic [HW-1:0]   r_height;
    logic [KW-1:0]   r_rem;
    logic [KW-1:0]   r_grp;
    logic [KW-1:0]   r_gsize;
    logic [GIDW-1:0] r_gidx;
    logic [NCW-1:0]  r_width;
    logic            r_dequant;

    logic w_in_load;
    logic w_real;
    logic w_adv;
    logic w_last;

    function automatic logic [HW-1:0] tile_height(input logic [KW-1:0] rows);
        return (rows >= KW'(Height)) ? H_FULL : rows[HW-1:0];
    endfunction

    // Nothing is strobed in a clear cycle, so the buffer never sees a half-accepted beat.
    assign w_in_load = (r_state == S_LOAD) && !clear_i;
    assign w_real    = (r_row < r_height);
    assign w_adv     = w_real ? w_valid_i : 1'b1;
    assign w_last    = (r_row == ROW_LAST);

    assign w_ready_o   = w_in_load && w_real && w_valid_i;
    assign load_o      = w_in_load && w_adv;
    assign w_data_o    = (w_in_load && w_real) ? w_data_i : '0;
    assign next_gidx_o = (load_o && r_dequant) ? r_gidx : '0;
    assign width_o     = r_width;
    assign height_o    = r_height;
    assign dequant_o   = r_dequant;
    assign busy_o      = (r_state != S_IDLE);
    assign tile_done_o = (r_state == S_GAP) && !clear_i;
    assign done_o      = (r_state == S_DONE) && !clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_height  <= '0;
            r_rem     <= '0;
            r_grp     <= '0;
            r_gsize   <= '0;
            r_gidx    <= '0;
            r_width   <= '0;
            r_dequant <= 1'b0;
        end else if (clear_i) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_height  <= '0;
            r_rem     <= '0;
            r_grp     <= '0;
            r_gsize   <= '0;
            r_gidx    <= '0;
            r_width   <= '0;
            r_dequant <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state   <= S_LOAD;
                        r_rem     <= k_rows_i;
                        r_row     <= '0;
                        r_grp     <= '0;
                        r_gidx    <= '0;
                        r_height  <= tile_height(k_rows_i);
                        r_width   <= (n_cols_i > D_MAX) ? D_MAX : n_cols_i;
                        r_dequant <= dequant_i;
                        r_gsize   <= group_size_i;
                    end
                end
                S_LOAD: begin
                    if (w_adv) begin
                        if (w_last) begin
                            r_row   <= '0;
                            r_state <= S_GAP;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                        // Group tracking by wrap counter avoids a row/group_size divider.
                        if (w_real) begin
                            r_rem <= r_rem - 1'b1;
                            if (r_grp == r_gsize - 1'b1) begin
                                r_grp  <= '0;
                                r_gidx <= r_gidx + 1'b1;
                            end else begin
                                r_grp <= r_grp + 1'b1;
                            end
                        end
                    end
                end
                S_GAP: begin
                    r_state <= (r_rem == '0) ? S_DONE : S_WAIT_REFILL;
                end
                S_WAIT_REFILL: begin
                    if (refill_i) begin
                        r_height <= tile_height(r_rem);
                        r_state  <= S_LOAD;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redmule_w_loader.sv
// Randomized bench for redmule_w_loader: expected load sequence is derived per job from
// K, H and group size with plain arithmetic, then matched against every load strobe.
module tb_redmule_w_loader;

    localparam int DW   = 288;
    localparam int H    = 4;
    localparam int D    = 18;
    localparam int NCW  = 6;
    localparam int HW   = 3;
    localparam int GIDW = 4;
    localparam int KW   = 16;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            clear_i;
    logic            start_i;
    logic [KW-1:0]   k_rows_i;
    logic [NCW-1:0]  n_cols_i;
    logic            dequant_i;
    logic [KW-1:0]   group_size_i;
    logic            w_valid_i;
    logic            w_ready_o;
    logic [DW-1:0]   w_data_i;
    logic            refill_i;
    logic            load_o;
    logic [DW-1:0]   w_data_o;
    logic [NCW-1:0]  width_o;
    logic [HW-1:0]   height_o;
    logic            dequant_o;
    logic [GIDW-1:0] next_gidx_o;
    logic            busy_o;
    logic            tile_done_o;
    logic            done_o;

    int n_checks = 0;
    int n_pass   = 0;

    redmule_w_loader #(
        .DW(DW), .FpFormat(2), .Height(H), .GID_WIDTH(16), .KW(KW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .k_rows_i(k_rows_i), .n_cols_i(n_cols_i), .dequant_i(dequant_i),
        .group_size_i(group_size_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .w_data_i(w_data_i), .refill_i(refill_i), .load_o(load_o), .w_data_o(w_data_o),
        .width_o(width_o), .height_o(height_o), .dequant_o(dequant_o),
        .next_gidx_o(next_gidx_o), .busy_o(busy_o), .tile_done_o(tile_done_o),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] b;
        for (int w = 0; w < DW / 32; w++) b[w*32 +: 32] = $urandom();
        return b;
    endfunction

    task automatic run_job(input int k, input int nc, input bit dq, input int gs,
                           input int vpct, input bit hold_rf, output int done_cyc);
        logic [DW-1:0] beats[$];
        logic [DW-1:0] e_data[$];
        int            e_gidx[$];
        int            e_h[$];
        bit            e_pad[$];
        logic [DW-1:0] ed;
        int ntiles, bi, tiles_seen, rf_wait, exp_w, h, eg, eh;
        bit done_seen, ep;

        ntiles = (k + H - 1) / H;
        bi = 0; tiles_seen = 0; rf_wait = -1; done_seen = 0; done_cyc = -1;
        exp_w = (nc > D) ? D : nc;
        for (int i = 0; i < k; i++) beats.push_back(rand_word());
        for (int t = 0; t < ntiles; t++) begin
            h = (k - t * H < H) ? k - t * H : H;
            for (int r = 0; r < H; r++) begin
                e_h.push_back(h);
                if (r < h) begin
                    e_data.push_back(beats[t * H + r]);
                    e_gidx.push_back(dq ? ((t * H + r) / gs) % 16 : 0);
                    e_pad.push_back(1'b0);
                end else begin
                    e_data.push_back('0);
                    e_gidx.push_back(dq ? ((t * H + h) / gs) % 16 : 0);
                    e_pad.push_back(1'b1);
                end
            end
        end

        for (int cyc = 0; cyc < 800 && !done_seen; cyc++) begin
            @(negedge clk_i);
            if (cyc == 0) begin
                start_i = 1'b1; k_rows_i = KW'(k); n_cols_i = NCW'(nc);
                dequant_i = dq; group_size_i = KW'(gs);
            end else begin
                start_i = 1'($urandom_range(1)); k_rows_i = KW'($urandom());
                n_cols_i = NCW'($urandom()); dequant_i = 1'($urandom_range(1));
                group_size_i = KW'($urandom_range(1, 7));
            end
            w_valid_i = (bi < k) && ($urandom_range(99) < vpct);
            w_data_i  = (bi < k) ? beats[bi] : rand_word();
            if (hold_rf) refill_i = 1'b1;
            else if (rf_wait == 0) begin refill_i = 1'b1; rf_wait = -1; end
            else begin refill_i = 1'b0; if (rf_wait > 0) rf_wait--; end
            #2;
            check("busy", busy_o, cyc >= 1);
            if (cyc == 0) check("done_idle", done_o, 0);
            if (load_o) begin
                if (e_data.size() == 0) check("extra_load", 1, 0);
                else begin
                    ed = e_data.pop_front(); eg = e_gidx.pop_front();
                    eh = e_h.pop_front(); ep = e_pad.pop_front();
                    check("w_data", w_data_o, ed);
                    check("gidx", next_gidx_o, eg);
                    check("height", height_o, eh);
                    check("width", width_o, exp_w);
                    check("dequant", dequant_o, dq);
                    check("ready", w_ready_o, !ep);
                    if (!ep) check("real_valid", w_valid_i, 1);
                end
            end else begin
                check("ready_no_load", w_ready_o, 0);
            end
            if (w_ready_o && w_valid_i) bi++;
            if (tile_done_o) begin
                tiles_seen++;
                if (tiles_seen < ntiles && !hold_rf) rf_wait = $urandom_range(2);
            end
            if (done_o) begin
                done_seen = 1'b1; done_cyc = cyc;
                check("tiles", tiles_seen, ntiles);
                check("beats", bi, k);
                check("loads_left", e_data.size(), 0);
            end
        end
        if (!done_seen) check("done_timeout", 0, 1);
        start_i = 1'b0; refill_i = 1'b0;
    endtask

    int dc;

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; k_rows_i = '0; n_cols_i = '0;
        dequant_i = 1'b0; group_size_i = '0; w_valid_i = 1'b0; w_data_i = '0; refill_i = 1'b0;
        #12;
        check("rst_busy", busy_o, 0);
        check("rst_load", load_o, 0);
        check("rst_height", height_o, 0);
        check("rst_width", width_o, 0);
        @(negedge clk_i); rst_ni = 1'b1;

        // full single tile: done lands 6 cycles after start
        run_job(4, D, 0, 1, 100, 0, dc);
        check("done_lat", dc, 6);
        run_job(6, 18, 0, 1, 100, 0, dc);      // partial tail with pads
        run_job(10, 18, 1, 3, 100, 0, dc);     // group indices
        run_job(8, 10, 1, 2, 33, 0, dc);       // backpressure
        run_job(4, 40, 0, 1, 100, 1, dc);      // refill held high, width saturates
        check("done_lat_rf", dc, 6);

        // clear in LOAD at row 2
        @(negedge clk_i);
        start_i = 1'b1; k_rows_i = 16'd8; n_cols_i = 6'd18; dequant_i = 1'b1;
        group_size_i = 16'd1; w_valid_i = 1'b1; w_data_i = rand_word();
        @(negedge clk_i); start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i); clear_i = 1'b1;
        #2;
        check("clr_load", load_o, 0);
        check("clr_ready", w_ready_o, 0);
        check("clr_done", done_o, 0);
        @(negedge clk_i); clear_i = 1'b0; w_valid_i = 1'b0;
        #2;
        check("clr_busy", busy_o, 0);
        check("clr_height", height_o, 0);
        run_job(5, 18, 1, 1, 100, 0, dc);

        // async reset mid-tile
        @(negedge clk_i);
        start_i = 1'b1; k_rows_i = 16'd8; n_cols_i = 6'd12; dequant_i = 1'b1;
        group_size_i = 16'd1; w_valid_i = 1'b1; w_data_i = rand_word();
        @(negedge clk_i); start_i = 1'b0;
        @(negedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        check("arst_load", load_o, 0);
        check("arst_ready", w_ready_o, 0);
        check("arst_data", w_data_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_width", width_o, 0);
        check("arst_height", height_o, 0);
        check("arst_dq", dequant_o, 0);
        check("arst_gidx", next_gidx_o, 0);
        @(negedge clk_i); rst_ni = 1'b1; w_valid_i = 1'b0;

        for (int j = 0; j < 12; j++) begin
            run_job($urandom_range(1, 40), $urandom_range(0, 63), 1'($urandom_range(1)),
                    $urandom_range(1, 5), $urandom_range(30, 100), 1'($urandom_range(1)), dc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
